keccak_squeeze_unit: RTL and testbench
======================================

KECCAK_SQUEEZE_UNIT -- requirements
Module: keccak_squeeze_unit

Interface
REQ-001 SHALL have parameter LANE_SIZE, default 64: Keccak lane width in bits, which is also the output beat width.
REQ-002 SHALL have parameter RATE_WIDTH, default 11: width of rate_i.
REQ-003 SHALL have parameter LEN_WIDTH, default 16: width of out_len_i and the remaining-bytes counter.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port start_i, input, 1: one-cycle pulse that starts a squeeze.
REQ-007 SHALL have port state_array_i, input, 1600: permuted state; lane A[x][y] occupies bits [64*(x+5y) +: 64].
REQ-008 SHALL have port rate_i, input, RATE_WIDTH: rate in bits, one of 1344, 1152, 1088, 832 or 576.
REQ-009 SHALL have port out_len_i, input, LEN_WIDTH: requested output length in bytes.
REQ-010 SHALL have port perm_req_o, output, 1: requests one further permutation from keccak_core.
REQ-011 SHALL have port perm_done_i, input, 1: one-cycle pulse; state_array_i holds the newly permuted state.
REQ-012 SHALL have port t_data_o, output, 64: AXI4-Stream source data, little-endian (output byte 0 on [7:0]).
REQ-013 SHALL have port t_keep_o, output, 8: AXI4-Stream byte enables.
REQ-014 SHALL have ports t_valid_o (output, 1), t_last_o (output, 1) and t_ready_i (input, 1): AXI4-Stream handshake.
REQ-015 SHALL have port busy_o, output, 1: high in every state except IDLE.
REQ-016 SHALL have port done_o, output, 1: one-cycle pulse when the squeeze completes.

Function
REQ-017 SHALL implement the FSM states IDLE, STREAM, WAIT_PERM and DONE.
REQ-018 In IDLE with start_i=1, SHALL capture state_array_i, rate_i and out_len_i, clear lane_idx to 0, load the remaining-bytes counter rem with out_len_i, and go to STREAM, or go to DONE if out_len_i=0.
REQ-019 SHALL ignore start_i outside IDLE.
REQ-020 SHALL assert t_valid_o in STREAM only, starting the cycle after start_i is accepted.
REQ-021 In STREAM, t_data_o SHALL equal captured lane lane_idx, where x = lane_idx mod 5 and y = lane_idx div 5.
REQ-022 t_keep_o SHALL be 8'hFF when rem >= 8, and otherwise SHALL have its low rem bits set and all other bits clear.
REQ-023 t_last_o SHALL be high exactly when t_valid_o=1 and rem <= 8.
REQ-024 t_data_o, t_keep_o and t_last_o SHALL be held stable while t_valid_o=1 and t_ready_i=0.
REQ-025 On a handshake (t_valid_o and t_ready_i both high), rem SHALL decrease by min(rem, 8) and lane_idx SHALL increment.
REQ-026 On a handshake with rem <= 8, SHALL go to DONE; this takes priority over REQ-027.
REQ-027 On a handshake with rem > 8 and lane_idx = rate/64 - 1, SHALL go to WAIT_PERM.
REQ-028 On any other handshake, SHALL remain in STREAM.
REQ-029 In WAIT_PERM, SHALL hold perm_req_o=1 and t_valid_o=0.
REQ-030 In WAIT_PERM with perm_done_i=1, SHALL capture state_array_i, clear lane_idx to 0, and return to STREAM on the next cycle.
REQ-031 SHALL ignore perm_done_i in any state other than WAIT_PERM.
REQ-032 In DONE, done_o SHALL be 1 for exactly one cycle, followed by an unconditional transition to IDLE.
REQ-033 rem SHALL never underflow; lane_idx SHALL be 5 bits and never exceed 20.
REQ-034 SHALL require no more than one perm_req_o episode per rate/8 bytes emitted.

Reset
REQ-035 While rst=0, SHALL force the FSM to IDLE, asynchronously.
REQ-036 While rst=0, SHALL clear t_valid_o, t_last_o, perm_req_o, busy_o and done_o to 0.
REQ-037 While rst=0, SHALL clear t_data_o, t_keep_o, lane_idx, rem and the captured state to 0.
REQ-038 Asserting rst mid-stream or in WAIT_PERM SHALL abort the squeeze with no further beats and no done_o pulse.

Verification
REQ-039 SHA3-256 case: rate 1088, len 32, t_ready_i=1 -> 4 beats (lanes 0..3) with keep FF each; t_last on beat 4; done_o pulses; perm_req_o never asserted.
REQ-040 SHAKE128 case: rate 1344, len 200 -> 21 beats; then perm_req_o held until perm_done_i; after that, 4 beats from lanes 0..3 of the new state, with the last beat keep FF and t_last=1.
REQ-041 Partial-beat case: len 13 -> 2 beats with keep FF then keep 1F; t_last on beat 2 only.
REQ-042 Backpressure case: t_ready_i toggled pseudo-randomly -> the output stream is byte-identical to the no-stall run, and data, keep and last are stable during stalls.
REQ-043 Zero-length and reset cases: len 0 -> no t_valid_o and a done_o pulse 1 cycle after start_i; rst=0 during beat 2 -> all outputs 0 immediately, and the FSM is in IDLE.

Source files
------------

// File: rtl/keccak_squeeze_unit.sv
// ---------------------------------------------------------------------------
// keccak_squeeze_unit
//
// Squeeze phase of a Keccak sponge. Takes a permuted 25-lane state, streams
// the rate portion out one lane per beat on an AXI4-Stream source, and asks
// keccak_core for another permutation whenever a rate block is exhausted and
// more output bytes are still owed.
//
// Ports
//   clk, rst          : clock (rising edge) and asynchronous active-low reset
//   start_i           : one-cycle pulse, starts a squeeze (ignored unless idle)
//   state_array_i     : permuted state, lane A[x][y] at [LANE_SIZE*(x+5y) +: LANE_SIZE]
//   rate_i            : sponge rate in bits (1344/1152/1088/832/576)
//   out_len_i         : requested output length in bytes
//   perm_req_o        : held high while waiting for the next permutation
//   perm_done_i       : one-cycle pulse, state_array_i holds the new state
//   t_data_o/t_keep_o : stream beat, little-endian, byte enables
//   t_valid_o/t_last_o/t_ready_i : stream handshake
//   busy_o            : high whenever not idle
//   done_o            : one-cycle pulse when the squeeze completes
// ---------------------------------------------------------------------------
module keccak_squeeze_unit #(
    parameter int LANE_SIZE  = 64,
    parameter int RATE_WIDTH = 11,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [25*LANE_SIZE-1:0] state_array_i,
    input  logic [RATE_WIDTH-1:0]  rate_i,
    input  logic [LEN_WIDTH-1:0]   out_len_i,
    output logic                   perm_req_o,
    input  logic                   perm_done_i,
    output logic [LANE_SIZE-1:0]   t_data_o,
    output logic [LANE_SIZE/8-1:0] t_keep_o,
    output logic                   t_valid_o,
    output logic                   t_last_o,
    input  logic                   t_ready_i,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int KEEP_W     = LANE_SIZE / 8;
    localparam int LANE_SHIFT = $clog2(LANE_SIZE);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_PERM = 2'd2,
        DONE      = 2'd3
    } state_e;

    // Control / datapath state
    state_e                         fsm_q, fsm_d;
    logic [24:0][LANE_SIZE-1:0]     st_q, st_d;
    logic [RATE_WIDTH-1:0]          rate_q, rate_d;
    logic [LEN_WIDTH-1:0]           rem_q, rem_d;
    logic [4:0]                     lane_q, lane_d;

    // Registered outputs
    logic [LANE_SIZE-1:0]           data_q, data_d;
    logic [KEEP_W-1:0]              keep_q, keep_d;
    logic                           valid_q, valid_d;
    logic                           last_q, last_d;
    logic                           preq_q, preq_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;

    logic                           hs;
    logic                           final_beat;
    logic                           block_end;
    logic [RATE_WIDTH-1:0]          blk_lanes;

    assign hs         = valid_q & t_ready_i;
    assign final_beat = (rem_q <= LEN_WIDTH'(KEEP_W));
    assign blk_lanes  = rate_q >> LANE_SHIFT;
    assign block_end  = (RATE_WIDTH'(lane_q) == blk_lanes - RATE_WIDTH'(1));

    always_comb begin
        fsm_d  = fsm_q;
        st_d   = st_q;
        rate_d = rate_q;
        rem_d  = rem_q;
        lane_d = lane_q;

        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    st_d   = state_array_i;
                    rate_d = rate_i;
                    rem_d  = out_len_i;
                    lane_d = 5'd0;
                    fsm_d  = (out_len_i == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (hs) begin
                    if (final_beat) begin
                        // Last beat wins over block end: no permutation
                        // is requested when nothing more is owed.
                        rem_d  = '0;
                        lane_d = 5'd0;
                        fsm_d  = DONE;
                    end else begin
                        rem_d = rem_q - LEN_WIDTH'(KEEP_W);
                        if (block_end) begin
                            // Park the index at 0 so it never walks past
                            // the largest rate's last lane.
                            lane_d = 5'd0;
                            fsm_d  = WAIT_PERM;
                        end else begin
                            lane_d = lane_q + 5'd1;
                        end
                    end
                end
            end
            WAIT_PERM: begin
                if (perm_done_i) begin
                    st_d   = state_array_i;
                    lane_d = 5'd0;
                    fsm_d  = STREAM;
                end
            end
            DONE: begin
                fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase

        // Outputs are computed from the next state so they appear in the
        // same cycle the FSM enters the state; without a handshake every
        // input to these terms is unchanged, so the beat holds steady.
        valid_d = (fsm_d == STREAM);
        last_d  = valid_d && (rem_d <= LEN_WIDTH'(KEEP_W));
        preq_d  = (fsm_d == WAIT_PERM);
        busy_d  = (fsm_d != IDLE);
        done_d  = (fsm_d == DONE);
        data_d  = st_d[lane_d];
        for (int b = 0; b < KEEP_W; b++) begin
            keep_d[b] = (rem_d > LEN_WIDTH'(b));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= IDLE;
            st_q    <= '0;
            rate_q  <= '0;
            rem_q   <= '0;
            lane_q  <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            preq_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            st_q    <= st_d;
            rate_q  <= rate_d;
            rem_q   <= rem_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            preq_q  <= preq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign t_data_o   = data_q;
    assign t_keep_o   = keep_q;
    assign t_valid_o  = valid_q;
    assign t_last_o   = last_q;
    assign perm_req_o = preq_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_keccak_squeeze_unit.sv
// ---------------------------------------------------------------------------
// tb_keccak_squeeze_unit
//
// Directed bench for keccak_squeeze_unit. Each state lane carries a unique
// tag (seed, lane number) so any wrong lane, stale state or wrong block is
// visible in t_data_o. Expected beats come from a byte-count model held in
// the bench.
// ---------------------------------------------------------------------------
module tb_keccak_squeeze_unit;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic [1599:0] state_array_i = '0;
    logic [10:0]   rate_i = '0;
    logic [15:0]   out_len_i = '0;
    logic          perm_req_o;
    logic          perm_done_i = 1'b0;
    logic [63:0]   t_data_o;
    logic [7:0]    t_keep_o;
    logic          t_valid_o;
    logic          t_last_o;
    logic          t_ready_i = 1'b0;
    logic          busy_o;
    logic          done_o;

    int errs   = 0;
    int checks = 0;

    keccak_squeeze_unit #(
        .LANE_SIZE (64),
        .RATE_WIDTH(11),
        .LEN_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .state_array_i(state_array_i),
        .rate_i       (rate_i),
        .out_len_i    (out_len_i),
        .perm_req_o   (perm_req_o),
        .perm_done_i  (perm_done_i),
        .t_data_o     (t_data_o),
        .t_keep_o     (t_keep_o),
        .t_valid_o    (t_valid_o),
        .t_last_o     (t_last_o),
        .t_ready_i    (t_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] lane_val(input logic [31:0] seed, input int i);
        logic [7:0] b;
        b = 8'(i);
        return {seed, 16'hBEEF, b, ~b};
    endfunction

    function automatic logic [1599:0] mk_state(input logic [31:0] seed);
        logic [1599:0] s;
        s = '0;
        for (int i = 0; i < 25; i++) s[i*64 +: 64] = lane_val(seed, i);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".valid"}, 64'(t_valid_o), 64'd0);
        chk({tag, ".last"},  64'(t_last_o),  64'd0);
        chk({tag, ".preq"},  64'(perm_req_o), 64'd0);
        chk({tag, ".busy"},  64'(busy_o),    64'd0);
        chk({tag, ".done"},  64'(done_o),    64'd0);
    endtask

    // Runs one squeeze. sa = initial state seed, sb = seed of every state
    // delivered on perm_done_i. stall randomises t_ready_i; poke pulses
    // start_i and perm_done_i (with a junk state) mid-stream, which must
    // both be ignored.
    task automatic squeeze(input string tag, input logic [31:0] sa, input logic [31:0] sb,
                           input int rate, input int len, input bit stall, input bit poke);
        int lanes, total, beats, rem, perms, exp_perms, wcnt, blk;
        bit exp_perm, pv_stall, ended, poked;
        logic [63:0] pd, ed;
        logic [7:0]  pk, ek;
        logic        pl;
        lanes     = rate / 64;
        total     = (len + 7) / 8;
        exp_perms = (total == 0) ? 0 : (total - 1) / lanes;
        @(negedge clk);
        state_array_i = mk_state(sa);
        rate_i        = 11'(rate);
        out_len_i     = 16'(len);
        start_i       = 1'b1;
        t_ready_i     = 1'b0;
        @(negedge clk);
        start_i       = 1'b0;
        state_array_i = mk_state(32'hDEAD_0000);
        beats = 0; rem = len; perms = 0; wcnt = 0;
        exp_perm = 0; pv_stall = 0; ended = 0; poked = 0;
        pd = '0; pk = '0; pl = 1'b0;
        for (int cyc = 0; cyc < 3000 && !ended; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (perm_done_i) state_array_i = mk_state(32'hDEAD_0001);
            perm_done_i = 1'b0;
            start_i     = 1'b0;
            if (rem == 0) begin
                chk({tag, ".done"},  64'(done_o),     64'd1);
                chk({tag, ".dvld"},  64'(t_valid_o),  64'd0);
                chk({tag, ".dpreq"}, 64'(perm_req_o), 64'd0);
                chk({tag, ".dbusy"}, 64'(busy_o),     64'd1);
                chk({tag, ".beats"}, 64'(beats),      64'(total));
                chk({tag, ".perms"}, 64'(perms),      64'(exp_perms));
                ended = 1;
            end else if (exp_perm) begin
                pv_stall = 0;
                chk({tag, ".wpreq"}, 64'(perm_req_o), 64'd1);
                chk({tag, ".wvld"},  64'(t_valid_o),  64'd0);
                chk({tag, ".wdone"}, 64'(done_o),     64'd0);
                wcnt++;
                if (wcnt == 3) begin
                    perm_done_i   = 1'b1;
                    state_array_i = mk_state(sb);
                    exp_perm      = 0;
                    wcnt          = 0;
                    perms++;
                end
            end else begin
                blk = beats / lanes;
                ed  = lane_val((blk == 0) ? sa : sb, beats % lanes);
                ek  = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
                chk({tag, ".vld"},  64'(t_valid_o),  64'd1);
                chk({tag, ".preq"}, 64'(perm_req_o), 64'd0);
                chk({tag, ".sdone"}, 64'(done_o),    64'd0);
                chk({tag, ".data"}, t_data_o,        ed);
                chk({tag, ".keep"}, 64'(t_keep_o),   64'(ek));
                chk({tag, ".last"}, 64'(t_last_o),   64'(rem <= 8));
                if (pv_stall) begin
                    chk({tag, ".hold_data"}, t_data_o,        pd);
                    chk({tag, ".hold_keep"}, 64'(t_keep_o),   64'(pk));
                    chk({tag, ".hold_last"}, 64'(t_last_o),   64'(pl));
                end
                pd = t_data_o; pk = t_keep_o; pl = t_last_o;
                t_ready_i = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                pv_stall  = !t_ready_i;
                if (t_ready_i) begin
                    beats++;
                    rem -= (rem < 8) ? rem : 8;
                    if (rem > 0 && (beats % lanes) == 0) exp_perm = 1;
                end
                if (poke && !poked && beats == 1 && rem > 0) begin
                    poked         = 1;
                    start_i       = 1'b1;
                    perm_done_i   = 1'b1;
                    state_array_i = mk_state(32'hBAD0_BAD0);
                end
            end
        end
        if (!ended) chk({tag, ".timeout"}, 64'd0, 64'd1);
        @(negedge clk);
        t_ready_i = 1'b0;
        chk({tag, ".idle_busy"}, 64'(busy_o), 64'd0);
        chk({tag, ".idle_done"}, 64'(done_o), 64'd0);
    endtask

    initial begin
        // Reset state
        #1;
        chk_quiet("rst");
        chk("rst.data", t_data_o, 64'd0);
        chk("rst.keep", 64'(t_keep_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        squeeze("sha3",  32'h5A30_0001, 32'hB000_0001, 1088, 32,  0, 1);
        squeeze("shake", 32'h5128_0002, 32'hB128_0002, 1344, 200, 0, 0);
        squeeze("part",  32'h0D00_0003, 32'hB000_0003, 576,  13,  0, 0);
        squeeze("bp",    32'h5128_0002, 32'hB128_0002, 1344, 200, 1, 0);
        squeeze("edge",  32'h0832_0004, 32'hB832_0004, 832,  104, 0, 0);
        squeeze("bp2",   32'h1152_0005, 32'hB152_0005, 1152, 150, 1, 0);
        squeeze("zero",  32'h0000_0006, 32'hB000_0006, 1088, 0,   0, 0);

        // Reset during beat 2
        @(negedge clk);
        state_array_i = mk_state(32'hC0DE_0007);
        rate_i        = 11'd1344;
        out_len_i     = 16'd200;
        start_i       = 1'b1;
        t_ready_i     = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("ar.beat1", t_data_o, lane_val(32'hC0DE_0007, 0));
        @(negedge clk);
        chk("ar.beat2", t_data_o, lane_val(32'hC0DE_0007, 1));
        rst = 1'b0;
        #1;
        chk_quiet("ar.now");
        chk("ar.data", t_data_o, 64'd0);
        chk("ar.keep", 64'(t_keep_o), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk_quiet("ar.hold");
        end
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("ar.idle");
        t_ready_i = 1'b0;

        squeeze("post", 32'h0900_0008, 32'hB900_0008, 576, 9, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
